tristate_bus_arbiter: RTL and testbench
=======================================

// Module: tristate_bus_arbiter
// PURPOSE
//  Upstream control stage for the shared tristate bus: decides which of N
//  sources may drive the bus and generates their one-hot tristate enables.
//  Uses round-robin fairness with a bounded hold time. Inserts turnaround
//  cycles with the bus released (all enables low, bus z) between owners, so
//  that two tristate drivers never contend.
// PARAMETERS
//  N           4   number of requesters, >= 2
//  WIDTH       4   bus data width per source
//  MAX_HOLD    8   maximum consecutive GRANT cycles per owner, >= 1
//  TURNAROUND  1   bus-released cycles between owners, >= 1
// PORTS
//  clk        in   1            rising-edge clock
//  reset      in   1            asynchronous, active-high reset
//  req        in   N            req[i]=1: source i wants the bus
//  d          in   N*WIDTH      source i data on d[i*WIDTH +: WIDTH]
//  en         out  N            one-hot tristate enables, registered
//  grant_id   out  $clog2(N)    index of current owner, valid when busy=1
//  busy       out  1            1 while in GRANT
//  y          out  WIDTH (tri)  shared bus: d of owner when en!=0, else z
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, en=0, grant_id=0, busy=0, y=z,
//   rr_ptr=0, hold_cnt=0, turn_cnt=0. Reset asserted mid-GRANT drops en and
//   floats y in the same instant, with no clock edge needed.
//  Arbitration pick: the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ...
//   modulo N.
//  States:
//   IDLE: en=0. If |req, next edge -> GRANT with owner=pick, en=onehot(pick),
//     hold_cnt=0. Latency is 1 cycle from req sampled to en asserted.
//   GRANT: en[owner]=1, busy=1, y=d[owner] combinationally through tristate.
//     hold_cnt increments each cycle. Exit on the edge where
//     req[owner]=0 OR hold_cnt==MAX_HOLD-1. On exit: en=0,
//     rr_ptr=(owner+1)%N, turn_cnt=0, go to TURN.
//   TURN: en=0, y=z, busy=0 for exactly TURNAROUND cycles. On its last
//     cycle, decide as IDLE does: if |req -> GRANT(pick), else -> IDLE.
//  Invariants: $onehot0(en) always. en!=0 iff state==GRANT. Never two owners
//   without >= TURNAROUND cycles of en==0 between them.
//  Requests: level-sensitive, with no queueing. A req dropped before grant
//   is forgotten. req changes of non-owners during GRANT have no effect
//   until the next decision point.
//  Same source re-requesting: after a MAX_HOLD timeout, the owner keeps req
//   high but competes again from rr_ptr=owner+1. It is re-granted only if
//   no other source is requesting.
//  Simultaneous events: owner drops req on the same edge as the hold limit
//   -> single exit to TURN. All N request at once -> grants rotate
//   rr_ptr, rr_ptr+1, ... in order.
//  grant_id holds its last value outside GRANT. d of non-owners is ignored.
// TESTING
//  1 Reset mid-GRANT: owner 2 granted, assert reset -> en=0, y=zzzz at
//    once; after release, state IDLE and rr_ptr=0.
//  2 Single request: req=0001 held 3 cycles then 0, d0=4'hA -> en=0001
//    from cycle 1, y=4'hA for 3 cycles, then en=0 for 1 cycle, then IDLE.
//  3 Round-robin: req=1111 held, MAX_HOLD=8 -> grant order 0,1,2,3,0, each
//    held 8 cycles, en=0000 for 1 cycle between consecutive owners.
//  4 Hold timeout: only req[1] high forever -> en=0010 for 8 cycles, en=0
//    for 1 cycle, en=0010 again, repeating.
//  5 Turnaround: TURNAROUND=3, req=0011 -> en=0000 for exactly 3 cycles
//    between owner 0 and owner 1. Assertion: $onehot0(en) every cycle and
//    y is never X.
//  6 Late requester: owner 0 active, req[3] rises then falls before the
//    next decision point -> source 3 is never granted.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter
//   Upstream control for a shared tristate bus. Picks one of N requesters
//   round-robin, gives it the bus for at most MAX_HOLD cycles, and puts
//   TURNAROUND cycles with the bus released (all enables low) between owners.
//   Two drivers are therefore never enabled at the same time.
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   req       req[i]=1: source i wants the bus (level, not queued)
//   d         source i data on d[i*WIDTH +: WIDTH]
//   en        one-hot tristate enables (registered)
//   grant_id  index of current owner; holds its last value outside GRANT
//   busy      1 while an owner holds the bus
//   y         shared bus: owner data while en!=0, otherwise z
module tristate_bus_arbiter #(
  parameter int N          = 4,
  parameter int WIDTH      = 4,
  parameter int MAX_HOLD   = 8,
  parameter int TURNAROUND = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   d,
  output logic [N-1:0]         en,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic [WIDTH-1:0]     y
);

  localparam int IDW = $clog2(N);
  localparam int HW  = (MAX_HOLD   > 1) ? $clog2(MAX_HOLD)   : 1;
  localparam int TW  = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [TW-1:0]    turn_cnt_q, turn_cnt_d;
  logic [N-1:0]     en_q, en_d;
  logic             busy_q, busy_d;

  logic             pick_vld;
  logic [IDW-1:0]   pick_id;

  // Round-robin pick: first requester scanning rr_ptr, rr_ptr+1, ... mod N.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = IDW'(idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
      en_q       <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d    = S_GRANT;
          grant_id_d = pick_id;
          hold_cnt_d = '0;
        end
      end
      S_GRANT: begin
        // Owner drop and hold limit on the same edge collapse into one exit.
        if (!req[grant_id_q] || hold_cnt_q == HW'(MAX_HOLD - 1)) begin
          state_d    = S_TURN;
          rr_ptr_d   = (grant_id_q == IDW'(N - 1)) ? '0 : grant_id_q + 1'b1;
          turn_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_TURN: begin
        if (turn_cnt_q == TW'(TURNAROUND - 1)) begin
          // Last released cycle doubles as an IDLE-style decision point.
          if (pick_vld) begin
            state_d    = S_GRANT;
            grant_id_d = pick_id;
            hold_cnt_d = '0;
          end else begin
            state_d    = S_IDLE;
          end
        end else begin
          turn_cnt_d = turn_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: enables/busy are registered from the next state so they
  // line up exactly with the GRANT state.
  always_comb begin
    en_d   = '0;
    busy_d = 1'b0;
    if (state_d == S_GRANT) begin
      en_d[grant_id_d] = 1'b1;
      busy_d           = 1'b1;
    end
  end

  assign en       = en_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;

  // Bus floats whenever no enable is set, including during reset.
  assign y = (en_q != '0) ? d[grant_id_q*WIDTH +: WIDTH] : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
module tb_tristate_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, req3;
  logic [15:0] d, d3;
  logic [3:0]  en, en3;
  logic [1:0]  gid, gid3;
  logic        busy, busy3;
  wire  [3:0]  y, y3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(.N(4), .WIDTH(4), .MAX_HOLD(8), .TURNAROUND(1)) dut (
    .clk(clk), .reset(reset), .req(req), .d(d),
    .en(en), .grant_id(gid), .busy(busy), .y(y)
  );

  tristate_bus_arbiter #(.N(4), .WIDTH(4), .MAX_HOLD(8), .TURNAROUND(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .d(d3),
    .en(en3), .grant_id(gid3), .busy(busy3), .y(y3)
  );

  typedef struct {
    logic [3:0]  req;
    logic [15:0] d;
    logic [3:0]  en;
    logic        busy;
    logic [1:0]  gid;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic void add(input logic [3:0] r, input logic [15:0] dd,
                              input logic [3:0] e, input logic [1:0] g);
    vec_t v;
    v.req = r; v.d = dd; v.en = e; v.busy = (e != 4'd0); v.gid = g;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Invariants on every cycle: one-hot enables, busy tracks enables, no X on a driven bus.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if (!$onehot0(en) || ((en != 4'd0) !== busy) || ((en != 4'd0) && $isunknown(y))) begin
        errors++;
        $display("FAIL invariant dut: en=%b busy=%b y=%b", en, busy, y);
      end
      checks++;
      if (!$onehot0(en3) || ((en3 != 4'd0) !== busy3) || ((en3 != 4'd0) && $isunknown(y3))) begin
        errors++;
        $display("FAIL invariant dut3: en=%b busy=%b y=%b", en3, busy3, y3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  localparam logic [15:0] D0 = 16'h4321;
  localparam logic [15:0] DA = 16'h357A;

  initial begin
    vec_t v;
    logic [3:0] ey;
    logic [3:0] e3;
    logic [1:0] g3;

    reset = 1'b1; req = '0; d = '0; req3 = '0; d3 = '0;
    #12;
    chk("reset en", 16'(en), 16'h0);
    chk("reset busy", 16'(busy), 16'h0);
    chk("reset gid", 16'(gid), 16'h0);
    @(negedge clk) reset = 1'b0;

    // Round-robin, all requesting: 0,1,2,3,0 each 8 cycles, 1 released cycle between.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 8; c++) add(4'hF, D0, 4'(1 << (r % 4)), 2'(r % 4));
      add((r == 4) ? 4'h0 : 4'hF, D0, 4'h0, 2'(r % 4));
    end
    add(4'h0, D0, 4'h0, 2'd0);
    // Single request held 3 cycles; non-owner data must not appear on the bus.
    for (int c = 0; c < 3; c++) add(4'h1, DA, 4'h1, 2'd0);
    add(4'h0, DA, 4'h0, 2'd0);
    add(4'h0, DA, 4'h0, 2'd0);
    // Hold timeout: lone requester 1 is re-granted after one released cycle.
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 8; c++) add(4'h2, DA, 4'h2, 2'd1);
      add((r == 0) ? 4'h2 : 4'h0, DA, 4'h0, 2'd1);
    end
    add(4'h0, DA, 4'h0, 2'd1);
    // Late requester 3 comes and goes during owner 0's tenure: never granted.
    add(4'h1, DA, 4'h1, 2'd0);
    for (int c = 0; c < 3; c++) add(4'h9, DA, 4'h1, 2'd0);
    add(4'h1, DA, 4'h1, 2'd0);
    add(4'h0, DA, 4'h0, 2'd0);
    add(4'h0, DA, 4'h0, 2'd0);

    foreach (tbl[i]) begin
      @(negedge clk);
      req = tbl[i].req;
      d   = tbl[i].d;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      v = exp_q.pop_front();
      chk($sformatf("vec%0d en", i), 16'(en), 16'(v.en));
      chk($sformatf("vec%0d busy", i), 16'(busy), 16'(v.busy));
      chk($sformatf("vec%0d gid", i), 16'(gid), 16'(v.gid));
      if (v.en != 4'd0) begin
        ey = v.d[v.gid*4 +: 4];
        chk($sformatf("vec%0d y", i), 16'(y), 16'(ey));
      end
    end

    // TURNAROUND=3: owner 0 for 8 cycles, exactly 3 released cycles, then owner 1.
    @(negedge clk);
    req3 = 4'h3;
    d3   = 16'h00C5;
    for (int c = 0; c < 14; c++) begin
      e3 = (c < 8) ? 4'h1 : (c < 11) ? 4'h0 : 4'h2;
      g3 = (c < 11) ? 2'd0 : 2'd1;
      v.req = req3; v.d = d3; v.en = e3; v.busy = (e3 != 4'd0); v.gid = g3;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      v = exp_q.pop_front();
      chk($sformatf("turn3 c%0d en", c), 16'(en3), 16'(v.en));
      chk($sformatf("turn3 c%0d gid", c), 16'(gid3), 16'(v.gid));
      if (v.en != 4'd0) begin
        ey = v.d[v.gid*4 +: 4];
        chk($sformatf("turn3 c%0d y", c), 16'(y3), 16'(ey));
      end
    end
    @(negedge clk) req3 = 4'h0;

    // Reset mid-GRANT with owner 2: enables drop with no clock edge.
    @(negedge clk);
    req = 4'h4; d = DA;
    @(posedge clk);
    #1;
    chk("pre-reset en", 16'(en), 16'h4);
    chk("pre-reset gid", 16'(gid), 16'h2);
    chk("pre-reset y", 16'(y), 16'h5);
    #2 reset = 1'b1;
    #1;
    chk("async reset en", 16'(en), 16'h0);
    chk("async reset busy", 16'(busy), 16'h0);
    chk("async reset gid", 16'(gid), 16'h0);
    @(negedge clk);
    reset = 1'b0; req = 4'h0;
    @(posedge clk);
    #1;
    chk("post-reset idle en", 16'(en), 16'h0);
    // rr_ptr must be back at 0: with all requesting, source 0 wins.
    @(negedge clk) req = 4'hF;
    @(posedge clk);
    #1;
    chk("post-reset rr en", 16'(en), 16'h1);
    chk("post-reset rr gid", 16'(gid), 16'h0);
    @(negedge clk) req = 4'h0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
